// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: types and constants shared by the data-memory stage and its RAM.
package cpu_mem_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int MAX_DATA_W = 128;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    // rdata is sized for the widest supported word and narrowed at the port.
    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [MAX_DATA_W-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x DATA_W RAM, synchronous byte-enabled write, registered read.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [DATA_W/8-1:0]      be_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DATA_W/8; b++)
                    if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_stage.sv
// dmem_stage: pipelined data-memory stage with address checking, fixed read latency
// and a halt/drain controller.
module dmem_stage
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic                halt,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                halted
);

    localparam int BW   = DATA_W / 8;
    localparam int OFF  = $clog2(BW);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CW   = $clog2(RD_LAT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic            v1_q, e1_q, r1_q;
    logic            accept, mis, oor, err;
    logic [DATA_W-1:0] ram_rdata;
    rsp_t            s1, rsp;

    assign accept = req_valid && req_ready;
    assign mis    = (req_addr & ADDR_W'(BW - 1)) != '0;
    assign oor    = (req_addr >> (OFF + IDXW)) != '0;
    assign err    = mis || oor;

    dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .en_i    (accept && !err),
        .we_i    (req_wr),
        .idx_i   (IDXW'(req_addr >> OFF)),
        .wdata_i (req_wdata),
        .be_i    (req_be),
        .rdata_o (ram_rdata)
    );

    // Stage 1 pairs the RAM's registered read with the request's status bits.
    assign s1 = '{valid: v1_q, err: e1_q, rdata: r1_q ? MAX_DATA_W'(ram_rdata) : '0};

    if (RD_LAT == 1) begin : g_direct
        assign rsp = s1;
    end else begin : g_pipe
        rsp_t pipe_q [RD_LAT-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < RD_LAT-1; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= s1;
                for (int i = 1; i < RD_LAT-1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign rsp = pipe_q[RD_LAT-2];
    end

    // Looking at the next count lets HALTED follow the last response directly.
    always_comb begin
        inflight_d = inflight_q + CW'(accept) - CW'(rsp.valid);
        state_d    = (state_q == RUN && halt) ? DRAIN :
                     (state_q == DRAIN && inflight_d == '0) ? HALTED : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            inflight_q <= '0;
            v1_q       <= 1'b0;
            e1_q       <= 1'b0;
            r1_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            v1_q       <= accept;
            e1_q       <= accept && err;
            r1_q       <= accept && !err && !req_wr;
        end
    end

    assign req_ready = state_q == RUN;
    assign halted    = state_q == HALTED;
    assign rsp_valid = rsp.valid;
    assign rsp_err   = rsp.err;
    assign rsp_rdata = DATA_W'(rsp.rdata);

endmodule

// File: doc/dmem_stage.md
DMEM_STAGE -- requirements
Module: dmem_stage

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter DEPTH, default 1024: number of DATA_W-bit words; SHALL be a power of 2.
REQ-004 Parameter RD_LAT, default 1: request-to-response latency in cycles; legal range 1..4.
REQ-005 Ports SHALL be, in this order:
- clk  in  1  the block's single clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at rising clk
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes
- halt  in  1  stop accepting requests and drain
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  response belongs to a faulted request
- halted  out  1  drain complete; sticky

Function
REQ-006 Each accepted request SHALL produce exactly one response, rsp_valid high for exactly one cycle, RD_LAT cycles after the accepting edge; responses SHALL be returned in acceptance order.
REQ-007 Response path has no backpressure; one request per cycle SHALL be sustainable (fully pipelined).
REQ-008 Word index = req_addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)].
REQ-009 Misaligned request (low log2(DATA_W/8) address bits nonzero) or out-of-range request (any address bit above the word-index field set) SHALL NOT modify memory and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-010 A write SHALL update only the bytes whose req_be bit is 1, committing at the accepting edge; req_be=0 SHALL be a legal no-op with rsp_err=0.
REQ-011 A read accepted the cycle after a write to the same word SHALL return the post-write data (no stale read).
REQ-012 A read and a write to the same word accepted in the same cycle are impossible, because acceptance is one request per cycle.
REQ-013 The control FSM SHALL have the states RUN, DRAIN and HALTED.
- RUN: req_ready=1.
- RUN to DRAIN on halt=1 sampled at a rising edge. A request accepted on that same edge is still serviced.
- DRAIN: req_ready=0. Moves to HALTED when no response is in flight.
- HALTED: req_ready=0, halted=1. Leaves HALTED only on reset.
REQ-014 In DRAIN and HALTED, halt deasserting SHALL have no effect.
REQ-015 The in-flight count SHALL be tracked with a counter of width clog2(RD_LAT+1); it never exceeds RD_LAT.

Reset
REQ-016 Asserting rst_n low SHALL asynchronously force:
- FSM to RUN
- req_ready=1 after release
- rsp_valid=0, rsp_err=0, rsp_rdata=0
- halted=0
- all pipeline valid bits and the in-flight counter to 0
REQ-017 Requests in flight when reset asserts SHALL produce no response.
REQ-018 Memory array contents SHALL NOT be reset.

Structure
REQ-019 A shared package cpu_mem_pkg SHALL hold the FSM state enum (RUN, DRAIN, HALTED), the response struct (valid, err, rdata) and the RD_LAT range constants.
REQ-020 The storage SHALL be a sub-module dmem_array: a single-port, synchronous-write, byte-enabled RAM of DEPTH x DATA_W. Decode, error check, latency pipeline and FSM live in dmem_stage.

Verification
REQ-021 With RD_LAT=1, scenario "write then read": write 0xDEADBEEF to address 0x10 with be=4'hF, then read 0x10 the next cycle -> read rsp_valid 1 cycle after acceptance, rdata=0xDEADBEEF, err=0.
REQ-022 Scenario "partial write": write 0x000000AA to address 0x10 with be=4'b0001 over 0xDEADBEEF, then read 0x10 -> rdata=0xDEADBEAA.
REQ-023 Scenario "errors": read 0x13 (misaligned) and write 0x1000 with DEPTH=1024 (out of range) -> both responses err=1, rdata=0, memory unchanged on re-read.
REQ-024 With RD_LAT=3, scenario "back-to-back": 4 consecutive reads to 0x0, 0x4, 0x8, 0xC -> 4 consecutive rsp_valid cycles starting 3 cycles after the first acceptance, in order.
REQ-025 With RD_LAT=3, scenario "halt drain": assert halt together with the third of 3 back-to-back requests -> all 3 responses delivered, req_ready low from the next cycle, halted=1 the cycle after the last response.
REQ-026 Scenario "reset mid-flight": assert rst_n=0 with 2 reads in flight -> no rsp_valid afterwards, halted=0, req_ready=1 after release.
